// File: rtl/e203_ifu_jbpu_if.sv
// IFU <-> jump/branch predictor signal bundle.
// master: IFU / mini-decoder / regfile side; slave: the predictor.
interface e203_ifu_jbpu_if #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RFIDX_W = 5
);

  // Decoded instruction and IFU handshake
  logic               dec_i_valid;
  logic               ifu_accept;
  logic               pipe_flush;
  logic [PC_W-1:0]    pc;
  logic               dec_jal;
  logic               dec_jalr;
  logic               dec_bxx;
  logic [XLEN-1:0]    dec_bjp_imm;
  logic [RFIDX_W-1:0] dec_jalr_rs1idx;

  // Hazard sources
  logic               oitf_empty;
  logic               ir_valid;
  logic               ir_rdwen;
  logic [RFIDX_W-1:0] ir_rdidx;
  logic               ir_rs1en;

  // Register file read paths
  logic [XLEN-1:0]    rf2bpu_x1;
  logic [XLEN-1:0]    rf2bpu_rs1;
  logic               bpu2rf_rs1_ena;

  // Prediction results
  logic               bpu_wait;
  logic               prdt_taken;
  logic [PC_W-1:0]    prdt_pc_add_op1;
  logic [PC_W-1:0]    prdt_pc_add_op2;

  modport master (
    output dec_i_valid, ifu_accept, pipe_flush, pc,
    output dec_jal, dec_jalr, dec_bxx, dec_bjp_imm, dec_jalr_rs1idx,
    output oitf_empty, ir_valid, ir_rdwen, ir_rdidx, ir_rs1en,
    output rf2bpu_x1, rf2bpu_rs1,
    input  bpu2rf_rs1_ena, bpu_wait, prdt_taken, prdt_pc_add_op1, prdt_pc_add_op2
  );

  modport slave (
    input  dec_i_valid, ifu_accept, pipe_flush, pc,
    input  dec_jal, dec_jalr, dec_bxx, dec_bjp_imm, dec_jalr_rs1idx,
    input  oitf_empty, ir_valid, ir_rdwen, ir_rdidx, ir_rs1en,
    input  rf2bpu_x1, rf2bpu_rs1,
    output bpu2rf_rs1_ena, bpu_wait, prdt_taken, prdt_pc_add_op1, prdt_pc_add_op2
  );

endinterface

// File: rtl/e203_ifu_jbpu.sv
// Static jump/branch predictor behind the IFU mini-decoder.
// jal: always taken; bxx: backward taken, forward not taken; jalr: taken,
// with the rs1 base resolved by a small hazard FSM that borrows the shared
// regfile rs1 read port for one cycle.
// Optional: define E203_BPU_JALR_X1_FAST_EN to serve jalr x1 from the
// dedicated rf2bpu_x1 path; otherwise x1 is resolved like any other rs1.
module e203_ifu_jbpu #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RFIDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  e203_ifu_jbpu_if.slave       bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_DEP = 2'd1,
    S_RD_RF    = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  state_e          r_state;
  state_e          w_nxt_state;
  logic            r_rs1_ena;
  logic [XLEN-1:0] r_rs1_q;

  logic            w_vld;
  logic            w_jalr_x0;
  logic            w_jalr_x1;
  logic            w_jalr_xn;
  logic            w_dep1;
  logic            w_depn;
  logic            w_wait;
  logic            w_rs1_load;
  logic            w_taken;
  logic [PC_W-1:0] w_op1;
  logic [PC_W-1:0] w_op2;

  // Outputs are forced quiet while reset is asserted, even with a valid decode
  assign w_vld = bus.dec_i_valid & rst_n;

  // jalr base register classification
  assign w_jalr_x0 = bus.dec_jalr & (bus.dec_jalr_rs1idx == RFIDX_W'(0));
`ifdef E203_BPU_JALR_X1_FAST_EN
  assign w_jalr_x1 = bus.dec_jalr & (bus.dec_jalr_rs1idx == RFIDX_W'(1));
  assign w_dep1    = ~bus.oitf_empty
                   | (bus.ir_valid & bus.ir_rdwen & (bus.ir_rdidx == RFIDX_W'(1)));
`else
  assign w_jalr_x1 = 1'b0;
  assign w_dep1    = 1'b0;
`endif
  assign w_jalr_xn = bus.dec_jalr & ~w_jalr_x0 & ~w_jalr_x1;

  // Generic rs1 hazard: outstanding long-pipe op, IR writing rs1, or IR holding the rs1 port
  assign w_depn = ~bus.oitf_empty
                | (bus.ir_valid & bus.ir_rdwen & (bus.ir_rdidx == bus.dec_jalr_rs1idx))
                | (bus.ir_valid & bus.ir_rs1en);

  // Next-state and stall generation
  always_comb begin
    w_nxt_state = r_state;
    w_wait      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_jalr_x1 && w_dep1) begin
          w_wait      = 1'b1;
          w_nxt_state = S_WAIT_DEP;
        end else if (w_jalr_xn) begin
          w_wait      = 1'b1;
          w_nxt_state = w_depn ? S_WAIT_DEP : S_RD_RF;
        end
      end
      S_WAIT_DEP: begin
        if (w_jalr_x1) begin
          if (w_dep1) begin
            w_wait = 1'b1;
          end else if (bus.ifu_accept) begin
            w_nxt_state = S_IDLE;
          end
        end else if (w_jalr_xn) begin
          w_wait = 1'b1;
          if (!w_depn) begin
            w_nxt_state = S_RD_RF;
          end
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      S_RD_RF: begin
        w_wait      = 1'b1;
        w_nxt_state = S_DONE;
      end
      S_DONE: begin
        if (bus.ifu_accept) begin
          w_nxt_state = S_IDLE;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
    // Losing the instruction abandons any resolution in progress
    if (!bus.dec_i_valid) begin
      w_wait      = 1'b0;
      w_nxt_state = S_IDLE;
    end
    // Flush outranks every other transition
    if (bus.pipe_flush) begin
      w_nxt_state = S_IDLE;
    end
  end

  // FSM state and registered rs1 port request (high exactly while in RD_RF)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rs1_ena <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_rs1_ena <= (w_nxt_state == S_RD_RF);
    end
  end

  // Capture the borrowed regfile read; a flushed or dropped read leaves the old value
  assign w_rs1_load = (r_state == S_RD_RF) & bus.dec_i_valid & ~bus.pipe_flush;

  // jalr base register captured from the shared rs1 port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1_q <= '0;
    end else if (w_rs1_load) begin
      r_rs1_q <= bus.rf2bpu_rs1;
    end
  end

  // Prediction and next-PC adder operands
  always_comb begin
    w_taken = 1'b0;
    w_op1   = '0;
    w_op2   = '0;
    if (w_vld) begin
      if (bus.dec_jal) begin
        w_taken = 1'b1;
        w_op1   = bus.pc;
        w_op2   = PC_W'(bus.dec_bjp_imm);
      end else if (bus.dec_jalr) begin
        w_taken = 1'b1;
        w_op2   = PC_W'(bus.dec_bjp_imm);
        if (w_jalr_x0) begin
          w_op1 = '0;
        end else if (w_jalr_x1) begin
`ifdef E203_BPU_JALR_X1_FAST_EN
          w_op1 = PC_W'(bus.rf2bpu_x1);
`else
          w_op1 = PC_W'(r_rs1_q);
`endif
        end else begin
          w_op1 = PC_W'(r_rs1_q);
        end
      end else if (bus.dec_bxx) begin
        w_taken = bus.dec_bjp_imm[XLEN-1];
        w_op1   = bus.pc;
        w_op2   = PC_W'(bus.dec_bjp_imm);
      end
    end
  end

  assign bus.prdt_taken      = w_taken;
  assign bus.prdt_pc_add_op1 = w_op1;
  assign bus.prdt_pc_add_op2 = w_op2;
  assign bus.bpu_wait        = w_wait & w_vld;
  assign bus.bpu2rf_rs1_ena  = r_rs1_ena;

endmodule

// File: tb/tb_e203_ifu_jbpu.sv
// Randomized self-checking bench for e203_ifu_jbpu against a cycle-count model.
module tb_e203_ifu_jbpu;

`ifdef E203_BPU_JALR_X1_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic [31:0] model_q;   // the block's captured jalr base register, as the spec defines it

  e203_ifu_jbpu_if #(.PC_W(32), .XLEN(32), .RFIDX_W(5)) u_if ();

  e203_ifu_jbpu #(.PC_W(32), .XLEN(32), .RFIDX_W(5)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    u_if.dec_i_valid = 0; u_if.ifu_accept = 0; u_if.pipe_flush = 0;
    u_if.pc = '0; u_if.dec_jal = 0; u_if.dec_jalr = 0; u_if.dec_bxx = 0;
    u_if.dec_bjp_imm = '0; u_if.dec_jalr_rs1idx = '0;
    u_if.oitf_empty = 1; u_if.ir_valid = 0; u_if.ir_rdwen = 0;
    u_if.ir_rdidx = '0; u_if.ir_rs1en = 0;
    u_if.rf2bpu_x1 = '0; u_if.rf2bpu_rs1 = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Idle and reset values
  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    model_q = '0;
    #3;
    vectors++; if (u_if.bpu_wait !== 1'b0) begin miscompares++; $display("FAIL rst_wait got %0b exp 0", u_if.bpu_wait); end
    vectors++; if (u_if.bpu2rf_rs1_ena !== 1'b0) begin miscompares++; $display("FAIL rst_ena got %0b exp 0", u_if.bpu2rf_rs1_ena); end
    vectors++; if (u_if.prdt_taken !== 1'b0) begin miscompares++; $display("FAIL rst_taken got %0b exp 0", u_if.prdt_taken); end
    vectors++; if (u_if.prdt_pc_add_op1 !== 32'h0) begin miscompares++; $display("FAIL rst_op1 got %h exp 0", u_if.prdt_pc_add_op1); end
    vectors++; if (u_if.prdt_pc_add_op2 !== 32'h0) begin miscompares++; $display("FAIL rst_op2 got %h exp 0", u_if.prdt_pc_add_op2); end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  // One jal (kind 0) or bxx (kind 1) instruction, accepted in the same cycle
  task automatic do_jb(input int kind, input logic [31:0] pcv, input logic [31:0] imm);
    logic exp_taken;
    drive_idle();
    u_if.dec_i_valid = 1; u_if.ifu_accept = 1;
    u_if.dec_jal = (kind == 0); u_if.dec_bxx = (kind != 0);
    u_if.pc = pcv; u_if.dec_bjp_imm = imm;
    u_if.dec_jalr_rs1idx = 5'($urandom);
    u_if.oitf_empty = 1'($urandom); u_if.ir_valid = 1'($urandom);
    u_if.ir_rdwen = 1'($urandom); u_if.ir_rs1en = 1'($urandom);
    exp_taken = (kind == 0) ? 1'b1 : ($signed(imm) < 0);
    @(negedge clk);
    vectors++; if (u_if.prdt_taken !== exp_taken) begin miscompares++; $display("FAIL jb_taken kind=%0d imm=%h got %0b exp %0b", kind, imm, u_if.prdt_taken, exp_taken); end
    vectors++; if (u_if.prdt_pc_add_op1 !== pcv) begin miscompares++; $display("FAIL jb_op1 got %h exp %h", u_if.prdt_pc_add_op1, pcv); end
    vectors++; if (u_if.prdt_pc_add_op2 !== imm) begin miscompares++; $display("FAIL jb_op2 got %h exp %h", u_if.prdt_pc_add_op2, imm); end
    vectors++; if (u_if.bpu_wait !== 1'b0) begin miscompares++; $display("FAIL jb_wait got %0b exp 0", u_if.bpu_wait); end
    vectors++; if (u_if.bpu2rf_rs1_ena !== 1'b0) begin miscompares++; $display("FAIL jb_ena got %0b exp 0", u_if.bpu2rf_rs1_ena); end
    next_cycle();
  endtask

  // One jalr through to acceptance; dependency held for the first d cycles
  task automatic run_jalr(input logic [4:0] rs1, input int d, input logic [31:0] x1val,
                          input logic [31:0] rd_fix, input bit use_fix);
    bit fast, xn, exp_w, exp_e;
    int wait_n, last, k;
    logic [31:0] pcv, imm, rdv, exp_op1;
    logic [4:0] idx;
    fast   = FAST && (rs1 == 5'd1);
    xn     = (rs1 != 5'd0) && !fast;
    wait_n = xn ? d + 2 : (fast ? d : 0);
    last   = wait_n + 1 + int'($urandom_range(0, 2));
    pcv = $urandom; imm = $urandom;
    for (int c = 1; c <= last; c++) begin
      drive_idle();
      u_if.dec_i_valid = 1; u_if.dec_jalr = 1; u_if.dec_jalr_rs1idx = rs1;
      u_if.pc = pcv; u_if.dec_bjp_imm = imm; u_if.rf2bpu_x1 = x1val;
      rdv = use_fix ? rd_fix : $urandom;
      u_if.rf2bpu_rs1 = rdv;
      u_if.ifu_accept = (c == last);
      idx = 5'($urandom);
      if (idx == rs1) idx = idx + 5'd1;
      u_if.ir_valid = 1'($urandom); u_if.ir_rdwen = 1'($urandom); u_if.ir_rdidx = idx;
      u_if.ir_rs1en = fast ? 1'($urandom) : 1'b0;
      if (c <= d) begin
        k = int'($urandom_range(0, fast ? 1 : 2));
        case (k)
          0: u_if.oitf_empty = 0;
          1: begin u_if.ir_valid = 1; u_if.ir_rdwen = 1; u_if.ir_rdidx = rs1; end
          default: begin u_if.ir_valid = 1; u_if.ir_rs1en = 1; end
        endcase
      end
      exp_w   = (c <= wait_n);
      exp_e   = xn && (c == d + 2);
      exp_op1 = (rs1 == 5'd0) ? 32'h0 : (fast ? x1val : model_q);
      @(negedge clk);
      vectors++; if (u_if.bpu_wait !== exp_w) begin miscompares++; $display("FAIL jalr_wait rs1=%0d d=%0d c=%0d got %0b exp %0b", rs1, d, c, u_if.bpu_wait, exp_w); end
      vectors++; if (u_if.bpu2rf_rs1_ena !== exp_e) begin miscompares++; $display("FAIL jalr_ena rs1=%0d d=%0d c=%0d got %0b exp %0b", rs1, d, c, u_if.bpu2rf_rs1_ena, exp_e); end
      vectors++; if (u_if.prdt_taken !== 1'b1) begin miscompares++; $display("FAIL jalr_taken rs1=%0d c=%0d got %0b exp 1", rs1, c, u_if.prdt_taken); end
      vectors++; if (u_if.prdt_pc_add_op1 !== exp_op1) begin miscompares++; $display("FAIL jalr_op1 rs1=%0d d=%0d c=%0d got %h exp %h", rs1, d, c, u_if.prdt_pc_add_op1, exp_op1); end
      vectors++; if (u_if.prdt_pc_add_op2 !== imm) begin miscompares++; $display("FAIL jalr_op2 rs1=%0d c=%0d got %h exp %h", rs1, c, u_if.prdt_pc_add_op2, imm); end
      @(posedge clk);
      if (exp_e) model_q = rdv;
      #1;
    end
    drive_idle();
  endtask

  task automatic test_jal_bxx();
    do_jb(0, 32'h8000_0000, 32'h0000_0100);
    do_jb(1, 32'h8000_0040, 32'hFFFF_FFF0);
    do_jb(1, 32'h8000_0080, 32'h0000_0010);
    for (int i = 0; i < 10; i++) do_jb(int'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  task automatic test_jalr_basic();
    run_jalr(5'd0, 2, $urandom, 32'h0, 1'b0);
    run_jalr(5'd1, 3, 32'h0000_1234, 32'h0, 1'b0);
    run_jalr(5'd1, 0, 32'h0000_5678, 32'h0, 1'b0);
    run_jalr(5'd5, 0, $urandom, 32'hABCD_0000, 1'b1);
    run_jalr(5'd5, 2, $urandom, 32'h1357_9BDF, 1'b1);
  endtask

  task automatic test_jalr_random();
    for (int i = 0; i < 20; i++)
      run_jalr(5'($urandom), int'($urandom_range(0, 4)), $urandom, 32'h0, 1'b0);
  endtask

  // Flush during the regfile read: back to IDLE, port request drops, base unchanged
  task automatic test_flush();
    logic [31:0] imm;
    imm = $urandom;
    for (int c = 1; c <= 4; c++) begin
      drive_idle();
      u_if.dec_i_valid = (c != 4); u_if.dec_jalr = 1; u_if.dec_jalr_rs1idx = 5'd5;
      u_if.dec_bjp_imm = imm; u_if.rf2bpu_rs1 = $urandom;
      u_if.pipe_flush = (c == 2) || (c == 3);
      @(negedge clk);
      vectors++; if (u_if.bpu_wait !== (c != 4)) begin miscompares++; $display("FAIL flush_wait c=%0d got %0b exp %0b", c, u_if.bpu_wait, (c != 4)); end
      vectors++; if (u_if.bpu2rf_rs1_ena !== (c == 2)) begin miscompares++; $display("FAIL flush_ena c=%0d got %0b exp %0b", c, u_if.bpu2rf_rs1_ena, (c == 2)); end
      vectors++; if (u_if.prdt_pc_add_op1 !== ((c == 4) ? 32'h0 : model_q)) begin miscompares++; $display("FAIL flush_op1 c=%0d got %h exp %h", c, u_if.prdt_pc_add_op1, (c == 4) ? 32'h0 : model_q); end
      next_cycle();
    end
    run_jalr(5'd5, 0, $urandom, 32'h0, 1'b0);
  endtask

  // Invalid decode gives zero outputs; dropping valid in DONE returns to IDLE
  task automatic test_invalid();
    logic [31:0] rdv;
    for (int i = 0; i < 4; i++) begin
      drive_idle();
      u_if.dec_jal = 1'($urandom); u_if.dec_jalr = 1'($urandom); u_if.dec_bxx = 1'($urandom);
      u_if.pc = $urandom; u_if.dec_bjp_imm = $urandom; u_if.dec_jalr_rs1idx = 5'($urandom);
      @(negedge clk);
      vectors++; if ({u_if.bpu_wait, u_if.prdt_taken, u_if.bpu2rf_rs1_ena} !== 3'b000) begin miscompares++; $display("FAIL inv_flags got %b exp 000", {u_if.bpu_wait, u_if.prdt_taken, u_if.bpu2rf_rs1_ena}); end
      vectors++; if ({u_if.prdt_pc_add_op1, u_if.prdt_pc_add_op2} !== 64'h0) begin miscompares++; $display("FAIL inv_ops got %h exp 0", {u_if.prdt_pc_add_op1, u_if.prdt_pc_add_op2}); end
      next_cycle();
    end
    for (int c = 1; c <= 3; c++) begin
      drive_idle();
      u_if.dec_i_valid = 1; u_if.dec_jalr = 1; u_if.dec_jalr_rs1idx = 5'd7;
      rdv = $urandom; u_if.rf2bpu_rs1 = rdv;
      @(negedge clk);
      vectors++; if (u_if.bpu_wait !== (c < 3)) begin miscompares++; $display("FAIL done_wait c=%0d got %0b exp %0b", c, u_if.bpu_wait, (c < 3)); end
      @(posedge clk);
      if (c == 2) model_q = rdv;
      #1;
    end
    drive_idle();
    @(negedge clk);
    vectors++; if (u_if.bpu2rf_rs1_ena !== 1'b0) begin miscompares++; $display("FAIL drop_ena got %0b exp 0", u_if.bpu2rf_rs1_ena); end
    next_cycle();
    run_jalr(5'd7, 0, $urandom, 32'h0, 1'b0);
  endtask

  // Asynchronous reset while waiting on a dependency
  task automatic test_reset_mid();
    drive_idle();
    u_if.dec_i_valid = 1; u_if.dec_jalr = 1; u_if.dec_jalr_rs1idx = 5'd5;
    u_if.dec_bjp_imm = $urandom; u_if.oitf_empty = 0;
    @(negedge clk);
    vectors++; if (u_if.bpu_wait !== 1'b1) begin miscompares++; $display("FAIL rmid_wait0 got %0b exp 1", u_if.bpu_wait); end
    next_cycle();
    #1;
    rst_n = 1'b0;
    model_q = '0;
    #1;
    vectors++; if ({u_if.bpu_wait, u_if.prdt_taken, u_if.bpu2rf_rs1_ena} !== 3'b000) begin miscompares++; $display("FAIL rmid_flags got %b exp 000", {u_if.bpu_wait, u_if.prdt_taken, u_if.bpu2rf_rs1_ena}); end
    vectors++; if ({u_if.prdt_pc_add_op1, u_if.prdt_pc_add_op2} !== 64'h0) begin miscompares++; $display("FAIL rmid_ops got %h exp 0", {u_if.prdt_pc_add_op1, u_if.prdt_pc_add_op2}); end
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();
    next_cycle();
    run_jalr(5'd5, 0, $urandom, 32'h0, 1'b0);
  endtask

  // Mixed instructions issued with no idle gap between them
  task automatic test_back_to_back();
    int kind;
    for (int i = 0; i < 15; i++) begin
      kind = int'($urandom_range(0, 2));
      if (kind == 2) run_jalr(5'($urandom), int'($urandom_range(0, 3)), $urandom, 32'h0, 1'b0);
      else do_jb(kind, $urandom, $urandom);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_jal_bxx();
    test_jalr_basic();
    test_jalr_random();
    test_flush();
    test_invalid();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
